// File: rtl/ps2_rx.sv
// PS/2 device-to-host receiver: synchronizer, clock glitch filter, frame FSM and FWFT receive FIFO.
// Optional PS2_RX_INHIBIT_EN holds clk_inhibit high while the FIFO is full.
module ps2_rx #(
  parameter int FIFO_AW = 3,
  parameter int TIMEOUT = 2048
) (
  input  logic       clk_core,
  input  logic       core_reset_n,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  input  logic       rd,
  input  logic       clear_err,
  output logic [7:0] data,
  output logic       valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       overflow,
  output logic       clk_inhibit
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int CW    = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  // Synchronizers and clock filter; all idle-high so reset looks like a quiet bus.
  logic       clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
  logic [1:0] hist_q;
  logic       filt_q, filt_d;
  logic       fall_q;

  // Frame receiver.
  state_t          state_q, state_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      shift_q, shift_d;
  logic            par_q, par_d;
  logic [CW-1:0]   tmo_q, tmo_d;
  logic            push_req, perr_set, ferr_set;

  // Receive FIFO and sticky flags.
  logic [7:0]         mem_q [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]   count_q, count_d;
  logic               full, pop, push_ok, ovf_set;
  logic               perr_q, perr_d, ferr_q, ferr_d, ovf_q, ovf_d;

  // A new filtered level is accepted only when the current and two previous samples agree.
  always_comb begin
    filt_d = filt_q;
    if (clk_s2_q == hist_q[0] && clk_s2_q == hist_q[1]) filt_d = clk_s2_q;
  end

  // NOTE: every clocked assignment uses <= so all flops see pre-edge values; = would
  // make results depend on statement order and simulate differently from the netlist.
  always_ff @(posedge clk_core or negedge core_reset_n) begin
    if (!core_reset_n) begin
      clk_s1_q <= 1'b1;
      clk_s2_q <= 1'b1;
      dat_s1_q <= 1'b1;
      dat_s2_q <= 1'b1;
      hist_q   <= 2'b11;
      filt_q   <= 1'b1;
      fall_q   <= 1'b0;
    end else begin
      clk_s1_q <= ps2_clk_in;
      clk_s2_q <= clk_s1_q;
      dat_s1_q <= ps2_data_in;
      dat_s2_q <= dat_s1_q;
      hist_q   <= {hist_q[0], clk_s2_q};
      filt_q   <= filt_d;
      fall_q   <= filt_q & ~filt_d;
    end
  end

  // NOTE: every variable gets a default before the case so no path leaves it
  // unassigned; otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_d     = par_q;
    tmo_d     = '0;
    push_req  = 1'b0;
    perr_set  = 1'b0;
    ferr_set  = 1'b0;

    if (state_q != IDLE) tmo_d = fall_q ? '0 : tmo_q + CW'(1);

    case (state_q)
      IDLE: begin
        if (fall_q && !dat_s2_q) begin
          state_d   = DATA;
          bit_cnt_d = 3'd0;
        end
      end
      DATA: begin
        if (fall_q) begin
          shift_d   = {dat_s2_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = PARITY;
        end
      end
      PARITY: begin
        if (fall_q) begin
          par_d   = dat_s2_q;
          state_d = STOP;
        end
      end
      STOP: begin
        if (fall_q) begin
          state_d = IDLE;
          if (!dat_s2_q)               ferr_set = 1'b1;
          else if (^{shift_q, par_q})  push_req = 1'b1;
          else                         perr_set = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // A stalled device abandons the frame; whatever was shifted in is simply dropped.
    if (state_q != IDLE && !fall_q && tmo_q == CW'(TIMEOUT)) begin
      state_d  = IDLE;
      tmo_d    = '0;
      ferr_set = 1'b1;
    end
  end

  assign valid   = (count_q != '0);
  assign full    = count_q[FIFO_AW];
  assign pop     = rd & valid;
  assign push_ok = push_req & (~full | pop);
  assign ovf_set = push_req & full & ~pop;
  assign data    = valid ? mem_q[rd_ptr_q] : 8'h00;

  always_comb begin
    wr_ptr_d = push_ok ? wr_ptr_q + FIFO_AW'(1) : wr_ptr_q;
    rd_ptr_d = pop     ? rd_ptr_q + FIFO_AW'(1) : rd_ptr_q;
    count_d  = count_q;
    if (push_ok && !pop)      count_d = count_q + (FIFO_AW+1)'(1);
    else if (!push_ok && pop) count_d = count_q - (FIFO_AW+1)'(1);
    // Setting beats clearing when both land in the same cycle.
    perr_d = (perr_q & ~clear_err) | perr_set;
    ferr_d = (ferr_q & ~clear_err) | ferr_set;
    ovf_d  = (ovf_q  & ~clear_err) | ovf_set;
  end

  always_ff @(posedge clk_core or negedge core_reset_n) begin
    if (!core_reset_n) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      par_q     <= 1'b0;
      tmo_q     <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      par_q     <= par_d;
      tmo_q     <= tmo_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
      ovf_q     <= ovf_d;
    end
  end

  // NOTE: the storage array has no reset so it maps onto RAM; the data output is
  // masked to zero while empty, so stale contents are never observable.
  always_ff @(posedge clk_core) begin
    if (push_ok) mem_q[wr_ptr_q] <= shift_q;
  end

  assign parity_err = perr_q;
  assign frame_err  = ferr_q;
  assign overflow   = ovf_q;

`ifdef PS2_RX_INHIBIT_EN
  logic inhibit_q;
  always_ff @(posedge clk_core or negedge core_reset_n) begin
    if (!core_reset_n) inhibit_q <= 1'b0;
    else               inhibit_q <= count_d[FIFO_AW];
  end
  assign clk_inhibit = inhibit_q;
`else
  assign clk_inhibit = 1'b0;
`endif

endmodule

// File: tb/tb_ps2_rx.sv
// Directed bench for ps2_rx: table of single-frame vectors plus hand-written FIFO,
// timeout, same-cycle and reset sequences.
module tb_ps2_rx;

  localparam int HALF    = 15;
  localparam int TIMEOUT = 2048;

  logic       clk_core = 1'b0;
  logic       core_reset_n = 1'b0;
  logic       ps2_clk_in = 1'b1;
  logic       ps2_data_in = 1'b1;
  logic       rd = 1'b0;
  logic       clear_err = 1'b0;
  logic [7:0] data;
  logic       valid, parity_err, frame_err, overflow, clk_inhibit;

  int n_cmp = 0;
  int n_fail = 0;

  ps2_rx #(.FIFO_AW(3), .TIMEOUT(TIMEOUT)) dut (
    .clk_core     (clk_core),
    .core_reset_n (core_reset_n),
    .ps2_clk_in   (ps2_clk_in),
    .ps2_data_in  (ps2_data_in),
    .rd           (rd),
    .clear_err    (clear_err),
    .data         (data),
    .valid        (valid),
    .parity_err   (parity_err),
    .frame_err    (frame_err),
    .overflow     (overflow),
    .clk_inhibit  (clk_inhibit)
  );

  always #5 clk_core = ~clk_core;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic [7:0] byte_v;
    logic       par;
    logic       stop;
    logic       exp_valid;
    logic [7:0] exp_data;
    logic       exp_perr;
    logic       exp_ferr;
  } vec_t;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
    end
  endtask

  function automatic logic odd_par(input logic [7:0] b);
    return ~^b;
  endfunction

  // Sends the first nbits of {start, data LSB-first, parity, stop}. The strobes are raised
  // for the single core cycle in which the stop-bit fall strobe is active: the pin drops just
  // after a falling core edge, two sync flops plus three agreeing filter samples put the strobe
  // high after the fifth rising edge.
  task automatic send_frame(input logic [7:0] b, input logic par, input logic stop,
                            input int nbits, input logic stb_rd, input logic stb_clr);
    logic [10:0] bits;
    bits = {stop, par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk_core) ps2_data_in = bits[i];
      repeat (HALF) @(negedge clk_core);
      ps2_clk_in = 1'b0;
      if (i == 10 && (stb_rd || stb_clr)) begin
        repeat (5) @(posedge clk_core);
        @(negedge clk_core);
        rd = stb_rd;
        clear_err = stb_clr;
        @(negedge clk_core);
        rd = 1'b0;
        clear_err = 1'b0;
      end
      repeat (HALF) @(negedge clk_core);
      ps2_clk_in = 1'b1;
    end
    ps2_data_in = 1'b1;
    repeat (HALF) @(negedge clk_core);
  endtask

  task automatic send_good(input logic [7:0] b);
    send_frame(b, odd_par(b), 1'b1, 11, 1'b0, 1'b0);
  endtask

  task automatic pop_check(input string name, input logic [7:0] exp);
    @(negedge clk_core);
    check(name, data, exp);
    rd = 1'b1;
    @(negedge clk_core);
    rd = 1'b0;
  endtask

  task automatic pulse_clear();
    @(negedge clk_core) clear_err = 1'b1;
    @(negedge clk_core) clear_err = 1'b0;
  endtask

  vec_t vecs [6];

  initial begin
    vecs[0] = '{8'h1C, 1'b0, 1'b1, 1'b1, 8'h1C, 1'b0, 1'b0};
    vecs[1] = '{8'h1C, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[2] = '{8'hF0, 1'b1, 1'b1, 1'b1, 8'hF0, 1'b0, 1'b0};
    vecs[3] = '{8'h00, 1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0};
    vecs[4] = '{8'hFF, 1'b1, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0};
    vecs[5] = '{8'hA5, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1};

    // Reset values.
    repeat (3) @(negedge clk_core);
    check("rst_data", data, 8'h00);
    check("rst_valid", {7'd0, valid}, 8'd0);
    check("rst_perr", {7'd0, parity_err}, 8'd0);
    check("rst_ferr", {7'd0, frame_err}, 8'd0);
    check("rst_ovf", {7'd0, overflow}, 8'd0);
    check("rst_inhibit", {7'd0, clk_inhibit}, 8'd0);
    core_reset_n = 1'b1;
    repeat (3) @(negedge clk_core);

    // Pop on an empty FIFO is ignored.
    rd = 1'b1;
    @(negedge clk_core) rd = 1'b0;
    @(negedge clk_core);
    check("empty_rd_valid", {7'd0, valid}, 8'd0);

    for (int v = 0; v < 6; v++) begin
      send_frame(vecs[v].byte_v, vecs[v].par, vecs[v].stop, 11, 1'b0, 1'b0);
      check($sformatf("vec%0d_valid", v), {7'd0, valid}, {7'd0, vecs[v].exp_valid});
      check($sformatf("vec%0d_data", v), data, vecs[v].exp_data);
      check($sformatf("vec%0d_perr", v), {7'd0, parity_err}, {7'd0, vecs[v].exp_perr});
      check($sformatf("vec%0d_ferr", v), {7'd0, frame_err}, {7'd0, vecs[v].exp_ferr});
      if (vecs[v].exp_valid) pop_check($sformatf("vec%0d_pop", v), vecs[v].exp_data);
      pulse_clear();
      @(negedge clk_core);
      check($sformatf("vec%0d_perr_clr", v), {7'd0, parity_err}, 8'd0);
      check($sformatf("vec%0d_ferr_clr", v), {7'd0, frame_err}, 8'd0);
      check($sformatf("vec%0d_empty", v), {7'd0, valid}, 8'd0);
    end

    // clear_err coinciding with a frame error: the new error must survive.
    send_frame(8'h3C, 1'b1, 1'b0, 11, 1'b0, 1'b1);
    check("setwins_ferr", {7'd0, frame_err}, 8'd1);
    pulse_clear();

    // Start plus five data bits, then silence longer than the timeout.
    send_frame(8'h1F, 1'b0, 1'b1, 6, 1'b0, 1'b0);
    check("tmo_pre_ferr", {7'd0, frame_err}, 8'd0);
    repeat (TIMEOUT + 50) @(negedge clk_core);
    check("tmo_ferr", {7'd0, frame_err}, 8'd1);
    check("tmo_valid", {7'd0, valid}, 8'd0);
    pulse_clear();
    send_good(8'hF0);
    check("tmo_next_valid", {7'd0, valid}, 8'd1);
    check("tmo_next_ferr", {7'd0, frame_err}, 8'd0);
    pop_check("tmo_next_data", 8'hF0);

    // Fill the FIFO with 0x01..0x08.
    for (int i = 1; i <= 8; i++) send_good(8'(i));
`ifdef PS2_RX_INHIBIT_EN
    check("full_inhibit", {7'd0, clk_inhibit}, 8'd1);
    pop_check("inh_pop1", 8'h01);
    check("inh_released", {7'd0, clk_inhibit}, 8'd0);
    for (int i = 2; i <= 8; i++) pop_check($sformatf("inh_pop%0d", i), 8'(i));
`else
    check("full_no_ovf", {7'd0, overflow}, 8'd0);
    send_good(8'h09);
    check("ovf_set", {7'd0, overflow}, 8'd1);
    check("ovf_inhibit", {7'd0, clk_inhibit}, 8'd0);
    for (int i = 1; i <= 8; i++) pop_check($sformatf("ovf_pop%0d", i), 8'(i));
`endif
    @(negedge clk_core);
    check("drained_valid", {7'd0, valid}, 8'd0);
    pulse_clear();

    // Full FIFO, pop in the push cycle of 0x55.
    for (int i = 0; i < 8; i++) send_good(8'h10 + 8'(i));
    send_frame(8'h55, odd_par(8'h55), 1'b1, 11, 1'b1, 1'b0);
    check("simul_no_ovf", {7'd0, overflow}, 8'd0);
    check("simul_valid", {7'd0, valid}, 8'd1);
    for (int i = 1; i < 8; i++) pop_check($sformatf("simul_pop%0d", i), 8'h10 + 8'(i));
    pop_check("simul_last", 8'h55);
    @(negedge clk_core);
    check("simul_empty", {7'd0, valid}, 8'd0);

    // Reset in the middle of a frame, with a byte already queued.
    send_good(8'h33);
    check("pre_rst_valid", {7'd0, valid}, 8'd1);
    send_frame(8'hAA, 1'b0, 1'b1, 5, 1'b0, 1'b0);
    @(negedge clk_core) core_reset_n = 1'b0;
    #1;
    check("mid_rst_valid", {7'd0, valid}, 8'd0);
    check("mid_rst_data", data, 8'h00);
    repeat (2) @(negedge clk_core);
    check("mid_rst_errs", {5'd0, parity_err, frame_err, overflow}, 8'd0);
    check("mid_rst_inhibit", {7'd0, clk_inhibit}, 8'd0);
    core_reset_n = 1'b1;
    repeat (3) @(negedge clk_core);
    send_good(8'h1C);
    check("post_rst_valid", {7'd0, valid}, 8'd1);
    check("post_rst_errs", {5'd0, parity_err, frame_err, overflow}, 8'd0);
    pop_check("post_rst_data", 8'h1C);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
